// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline control slice: FSM state
// encoding, ALU opcode set, default memory timeout and a PC alignment helper.
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } pipe_ctrl_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opcode_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 32'd255;

  // Redirect targets are halfword aligned; bit 0 is always forced low.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Bundle of pipeline status inputs and control outputs exchanged between the
// datapath (master) and the pipeline control block (slave).
interface pipeline_control_if;

  logic        i_id_valid;
  logic [4:0]  i_id_rs1_id;
  logic [4:0]  i_id_rs2_id;
  logic        i_id_uses_rs1;
  logic        i_id_uses_rs2;
  logic        i_ex_valid;
  logic [4:0]  i_ex_rd_id;
  logic        i_ex_is_load;
  logic        i_redirect;
  logic [31:0] i_redirect_addr;
  logic        i_mem_req;
  logic        i_mem_ack;

  logic        o_stall_if;
  logic        o_stall_id;
  logic        o_stall_ex;
  logic        o_flush_if_id;
  logic        o_flush_id_ex;
  logic        o_pc_load;
  logic [31:0] o_pc_target;
  logic        o_mem_timeout;
  logic [31:0] o_stall_cycles;
  logic [31:0] o_redirect_count;

  modport master (
    output i_id_valid, i_id_rs1_id, i_id_rs2_id, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_valid, i_ex_rd_id, i_ex_is_load, i_redirect, i_redirect_addr,
           i_mem_req, i_mem_ack,
    input  o_stall_if, o_stall_id, o_stall_ex, o_flush_if_id, o_flush_id_ex,
           o_pc_load, o_pc_target, o_mem_timeout, o_stall_cycles, o_redirect_count
  );

  modport slave (
    input  i_id_valid, i_id_rs1_id, i_id_rs2_id, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_valid, i_ex_rd_id, i_ex_is_load, i_redirect, i_redirect_addr,
           i_mem_req, i_mem_ack,
    output o_stall_if, o_stall_id, o_stall_ex, o_flush_if_id, o_flush_id_ex,
           o_pc_load, o_pc_target, o_mem_timeout, o_stall_cycles, o_redirect_count
  );

endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Writes to x0 never create a dependency.
module hazard_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_id_i,
  input  logic [4:0] id_rs2_id_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_id_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic rs1_match_s;
  logic rs2_match_s;

  assign rs1_match_s = id_uses_rs1_i & (id_rs1_id_i == ex_rd_id_i);
  assign rs2_match_s = id_uses_rs2_i & (id_rs2_id_i == ex_rd_id_i);
  assign load_use_o  = id_valid_i & ex_valid_i & ex_is_load_i &
                       (ex_rd_id_i != 5'd0) & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control FSM: memory stalls, redirects and load-use bubbles with
// zero-latency control outputs and registered stall/redirect counters.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic               i_clk,
  input logic               i_rst,
  pipeline_control_if.slave bus
);

  pipe_ctrl_state_t state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  logic        load_use_s;
  logic        mem_stall_s;
  logic        stall_if_s, stall_id_s, stall_ex_s;
  logic        flush_if_id_s, flush_id_ex_s, pc_load_s, mem_timeout_s;
  logic [31:0] pc_target_s;

  hazard_detect u_hazard_detect (
    .id_valid_i    (bus.i_id_valid),
    .id_rs1_id_i   (bus.i_id_rs1_id),
    .id_rs2_id_i   (bus.i_id_rs2_id),
    .id_uses_rs1_i (bus.i_id_uses_rs1),
    .id_uses_rs2_i (bus.i_id_uses_rs2),
    .ex_valid_i    (bus.i_ex_valid),
    .ex_rd_id_i    (bus.i_ex_rd_id),
    .ex_is_load_i  (bus.i_ex_is_load),
    .load_use_o    (load_use_s)
  );

  assign mem_stall_s = bus.i_mem_req & ~bus.i_mem_ack;

  // Next-state and control decode; reset forces every output low immediately.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_if_s    = 1'b0;
    stall_id_s    = 1'b0;
    stall_ex_s    = 1'b0;
    flush_if_id_s = 1'b0;
    flush_id_ex_s = 1'b0;
    pc_load_s     = 1'b0;
    pc_target_s   = 32'd0;
    mem_timeout_s = 1'b0;
    if (i_rst) begin
      state_d    = ST_RUN;
      wait_cnt_d = 32'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall_s) begin
            stall_if_s = 1'b1;
            stall_id_s = 1'b1;
            stall_ex_s = 1'b1;
            wait_cnt_d = 32'd0;
            state_d    = ST_MEM_WAIT;
          end else if (bus.i_redirect) begin
            pc_load_s     = 1'b1;
            pc_target_s   = align_pc(bus.i_redirect_addr);
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            state_d       = ST_REDIRECT;
          end else if (load_use_s) begin
            stall_if_s    = 1'b1;
            stall_id_s    = 1'b1;
            flush_id_ex_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        // The cycle that acks or times out releases the stall combinationally.
        ST_MEM_WAIT: begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if (bus.i_mem_ack) begin
            state_d = ST_RUN;
          end else if (wait_cnt_d == MEM_TIMEOUT) begin
            mem_timeout_s = 1'b1;
            state_d       = ST_RUN;
          end else begin
            stall_if_s = 1'b1;
            stall_id_s = 1'b1;
            stall_ex_s = 1'b1;
          end
        end
        ST_REDIRECT: begin
          flush_if_id_s = 1'b1;
          state_d       = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign stall_cycles_d   = stall_cycles_q + {31'd0, stall_if_s};
  assign redirect_count_d = redirect_count_q + {31'd0, pc_load_s};

  // FSM state, wait counter and performance counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ST_RUN;
      wait_cnt_q       <= 32'd0;
      stall_cycles_q   <= 32'd0;
      redirect_count_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.o_stall_if       = stall_if_s;
  assign bus.o_stall_id       = stall_id_s;
  assign bus.o_stall_ex       = stall_ex_s;
  assign bus.o_flush_if_id    = flush_if_id_s;
  assign bus.o_flush_id_ex    = flush_id_ex_s;
  assign bus.o_pc_load        = pc_load_s;
  assign bus.o_pc_target      = pc_target_s;
  assign bus.o_mem_timeout    = mem_timeout_s;
  assign bus.o_stall_cycles   = stall_cycles_q;
  assign bus.o_redirect_count = redirect_count_q;

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports i_id_valid  input  1, i_id_rs1_id  input  5, i_id_rs2_id  input  5, i_id_uses_rs1  input  1, i_id_uses_rs2  input  1: the decode-stage instruction and the source registers it reads.
REQ-004 SHALL have ports i_ex_valid  input  1, i_ex_rd_id  input  5, i_ex_is_load  input  1: the execute-stage instruction and its destination.
REQ-005 SHALL have ports i_redirect  input  1, i_redirect_addr  input  32: branch taken or jump resolved in EX.
REQ-006 SHALL have ports i_mem_req  input  1, i_mem_ack  input  1: data-memory access issued by MEM and its completion.
REQ-007 SHALL have outputs o_stall_if, o_stall_id, o_stall_ex, o_flush_if_id, o_flush_id_ex, o_pc_load, each 1 bit: pipeline control.
REQ-008 SHALL have outputs o_pc_target  32, o_mem_timeout  1, o_stall_cycles  32, o_redirect_count  32.
REQ-009 SHALL have parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before abort.

Function
REQ-010 SHALL implement an FSM with states RUN, MEM_WAIT and REDIRECT.
REQ-011 Priority in RUN SHALL be memory stall > redirect > load-use.
REQ-012 Load-use hazard SHALL be i_id_valid & i_ex_valid & i_ex_is_load & (i_ex_rd_id != 0) & ((i_id_uses_rs1 & rs1 == rd) | (i_id_uses_rs2 & rs2 == rd)).
REQ-013 On a load-use hazard in RUN, the block SHALL combinationally assert o_stall_if, o_stall_id and o_flush_id_ex in the same cycle (one bubble), and SHALL remain in RUN.
REQ-014 On i_redirect in RUN with no memory stall, the block SHALL in the same cycle assert o_pc_load, set o_pc_target = {i_redirect_addr[31:1], 1'b0}, assert o_flush_if_id and o_flush_id_ex, and then go to REDIRECT.
REQ-015 REDIRECT SHALL last exactly one cycle, assert only o_flush_if_id (killing the in-flight fetch), ignore i_redirect and load-use, and then return to RUN.
REQ-016 On i_mem_req & !i_mem_ack in RUN, the block SHALL assert o_stall_if, o_stall_id and o_stall_ex combinationally and go to MEM_WAIT.
REQ-017 i_mem_req & i_mem_ack in the same RUN cycle SHALL NOT stall.
REQ-018 MEM_WAIT SHALL hold o_stall_if, o_stall_id and o_stall_ex high on every cycle.
REQ-019 The block SHALL ignore i_redirect in MEM_WAIT; EX holds the redirect while stalled, so it is serviced in the first RUN cycle after the stall.
REQ-020 MEM_WAIT SHALL return to RUN on the cycle after i_mem_ack; stalls SHALL deassert combinationally in the ack cycle.
REQ-021 A wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle.
REQ-022 When the wait counter reaches MEM_TIMEOUT without ack, the block SHALL pulse o_mem_timeout for one cycle and return to RUN.
REQ-023 o_stall_cycles SHALL increment by 1 on every cycle o_stall_if = 1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 o_redirect_count SHALL increment by 1 on every o_pc_load pulse, and SHALL wrap.
REQ-025 o_pc_target SHALL be 0 whenever o_pc_load = 0.
REQ-026 Control outputs SHALL be pure functions of the state and current inputs (zero-cycle latency).
REQ-027 Counters and the FSM SHALL be registered.

Reset
REQ-028 While i_rst = 1, the FSM SHALL be in RUN, and all control outputs, o_pc_target, o_mem_timeout, both counters and the wait counter SHALL be 0.
REQ-029 Reset asserted during MEM_WAIT or REDIRECT SHALL abort the operation immediately; the block SHALL emit no pending pulse after release.
REQ-030 The first cycle after reset release SHALL evaluate inputs normally in RUN.

Structure
REQ-031 The state enum pipe_ctrl_state_t and the default MEM_TIMEOUT constant SHALL reside in the shared package alongside alu_opcode_t.
REQ-032 Load-use detection SHALL be a combinational sub-module hazard_detect instantiated once.

Verification
REQ-033 Load x5 in EX, ID reads rs2 = x5 with uses_rs2 = 1 -> one cycle of stall_if = stall_id = flush_id_ex = 1, then normal flow; stall_cycles = 1.
REQ-034 Load with rd = x0 in EX, ID reads x0 -> no stall.
REQ-035 i_redirect with addr 0x0000_1003 -> pc_load = 1 and target 0x0000_1002 in the same cycle; flush_if_id = 1 for 2 cycles; redirect_count = 1.
REQ-036 mem_req with ack after 3 cycles and redirect held throughout -> stalls for 3 cycles, redirect serviced on the next cycle, stall_cycles = 3.
REQ-037 mem_req with no ack and MEM_TIMEOUT = 4 -> 4 stall cycles, o_mem_timeout pulses once, FSM returns to RUN.
REQ-038 i_rst pulsed mid-MEM_WAIT -> all outputs 0 asynchronously; FSM in RUN after release; counters 0.
